// File: rtl/riscv_nn_defines.sv
// -----------------------------------------------------------------------------
// riscv_nn_defines
// Shared types for the IF-stage instruction aligner.
//   aligner_state_e : where the next instruction starts relative to the
//                     current fetch word (2-bit encoding).
// -----------------------------------------------------------------------------
package riscv_nn_defines;

    typedef enum logic [1:0] {
        ALIGNED           = 2'd0,  // next instruction starts at bit 0 of the fetch word
        MISALIGNED        = 2'd1,  // next instruction starts in hword_q
        BRANCH_MISALIGNED = 2'd2   // branch target at pc[1]=1, low half of next word is dropped
    } aligner_state_e;

    // A halfword opens a 32-bit instruction iff its two low bits are 11.
    function automatic logic is_full_len(input logic [15:0] hword);
        return (hword[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/riscv_nn_instr_aligner.sv
// -----------------------------------------------------------------------------
// riscv_nn_instr_aligner
// Realigns the word-aligned 32-bit fetch stream into complete 16/32-bit
// instructions starting at bit 0, each tagged with its PC.
//
// Ports:
//   clk, rst_n        : core clock, asynchronous active-low reset
//   fetch_valid_i     : fetch word valid
//   fetch_ready_o     : fetch word consumed this cycle
//   fetch_rdata_i     : 32-bit fetch word (held stable while valid & !ready)
//   instr_valid_o     : aligned instruction valid
//   instr_ready_i     : ID stage accepts the instruction
//   instr_aligned_o   : aligned instruction, upper half zero when compressed
//   instr_addr_o      : PC of instr_aligned_o
//   branch_i          : single-cycle redirect pulse
//   branch_addr_i     : redirect target (bit 0 ignored)
// -----------------------------------------------------------------------------
module riscv_nn_instr_aligner
    import riscv_nn_defines::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic [31:0] instr_addr_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    aligner_state_e state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [15:0]    hword_q, hword_d;

    logic           valid_c;
    logic           ready_c;
    logic [31:0]    aligned_c;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hword_d   = hword_q;
        valid_c   = 1'b0;
        ready_c   = 1'b0;
        aligned_c = 32'h0;

        case (state_q)
            ALIGNED: begin
                valid_c   = fetch_valid_i;
                ready_c   = fetch_valid_i & instr_ready_i;
                if (is_full_len(fetch_rdata_i[15:0])) begin
                    aligned_c = fetch_rdata_i;
                    if (fetch_valid_i && instr_ready_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    aligned_c = {16'h0, fetch_rdata_i[15:0]};
                    if (fetch_valid_i && instr_ready_i) begin
                        hword_d = fetch_rdata_i[31:16];
                        pc_d    = pc_q + 32'd2;
                        state_d = MISALIGNED;
                    end
                end
            end

            MISALIGNED: begin
                if (!is_full_len(hword_q)) begin
                    // Compressed instruction already buffered: issue without a fetch.
                    valid_c   = 1'b1;
                    aligned_c = {16'h0, hword_q};
                    if (instr_ready_i) begin
                        pc_d    = pc_q + 32'd2;
                        state_d = ALIGNED;
                    end
                end else begin
                    // 32-bit instruction straddles the word boundary.
                    valid_c   = fetch_valid_i;
                    ready_c   = fetch_valid_i & instr_ready_i;
                    aligned_c = {fetch_rdata_i[15:0], hword_q};
                    if (fetch_valid_i && instr_ready_i) begin
                        hword_d = fetch_rdata_i[31:16];
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end

            BRANCH_MISALIGNED: begin
                // Drop the low half of the target word; one bubble cycle.
                ready_c = fetch_valid_i;
                if (fetch_valid_i) begin
                    hword_d = fetch_rdata_i[31:16];
                    state_d = MISALIGNED;
                end
            end

            default: begin
                state_d = ALIGNED;
            end
        endcase

        // A redirect overrides any transfer in the same cycle.
        if (branch_i) begin
            valid_c = 1'b0;
            ready_c = 1'b0;
            hword_d = hword_q;
            pc_d    = {branch_addr_i[31:1], 1'b0};
            state_d = branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            hword_q <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hword_q <= hword_d;
        end
    end

    // Handshake and data are masked while reset is held so nothing leaks
    // out combinationally from the fetch port during reset.
    assign instr_valid_o   = valid_c & rst_n;
    assign fetch_ready_o   = ready_c & rst_n;
    assign instr_aligned_o = rst_n ? aligned_c : 32'h0;
    assign instr_addr_o    = pc_q;

endmodule

// File: doc/riscv_nn_instr_aligner.md
Name: riscv_nn_instr_aligner

Overview:
- Sits in the IF stage between the prefetch buffer (word-aligned 32-bit fetch words) and riscv_nn_compressed_decoder.
- Realigns the mixed 16/32-bit instruction stream so each output is one complete instruction, starting at bit 0, with its PC.
- Handles 32-bit instructions that straddle a word boundary, back-to-back compressed instructions within one word, and branches to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset. The first branch_i after reset normally overrides it.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous reset, active low
- fetch_valid_i  in  1  fetch word valid
- fetch_ready_o  out  1  fetch word consumed this cycle (valid & ready)
- fetch_rdata_i  in  32  fetch word; upstream holds it stable while valid & !ready
- instr_valid_o  out  1  aligned instruction valid
- instr_ready_i  in  1  ID stage accepts instruction
- instr_aligned_o  out  32  aligned instruction; upper 16 bits are zero for compressed
- instr_addr_o  out  32  PC of instr_aligned_o
- branch_i  in  1  redirect (jump/branch/exception), single-cycle pulse
- branch_addr_i  in  32  redirect target; bit 0 is ignored

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active low.
- Reset values: state = ALIGNED, pc_q = RESET_PC, hword_q = 16'h0. Outputs at reset: instr_valid_o = 0, fetch_ready_o = 0, instr_aligned_o = 0, instr_addr_o = RESET_PC.
- Registers: pc_q[31:0]; hword_q[15:0] (upper half of the last consumed word); state.
- Length rule: a halfword h is a 32-bit instruction start iff h[1:0] == 2'b11, otherwise compressed. 48-bit and longer encodings are not supported and are treated as 32-bit.
- Latency and ordering: zero-latency combinational path from fetch_rdata_i to instr_aligned_o. instr_valid_o never depends on instr_ready_i. Outputs stay stable while valid & !ready.
- instr_addr_o = pc_q in every state.
- ALIGNED state:
  - instr_valid_o = fetch_valid_i.
  - If fetch_rdata_i[1:0] == 11: output fetch_rdata_i. On accept: pc += 4, stay.
  - Else (compressed): output {16'h0, fetch_rdata_i[15:0]}. On accept: hword_q <= fetch_rdata_i[31:16], pc += 2, go to MISALIGNED.
  - fetch_ready_o = fetch_valid_i & instr_ready_i. The word is always consumed on accept.
- MISALIGNED state (pc[1] == 1, hword_q holds the instruction start):
  - If hword_q[1:0] != 11: instr_valid_o = 1 with no fetch needed; output {16'h0, hword_q}; fetch_ready_o = 0. On accept: pc += 2, go to ALIGNED.
  - Else: instr_valid_o = fetch_valid_i; output {fetch_rdata_i[15:0], hword_q}; fetch_ready_o = fetch_valid_i & instr_ready_i. On accept: hword_q <= fetch_rdata_i[31:16], pc += 4, stay.
- BRANCH_MISALIGNED state:
  - instr_valid_o = 0; fetch_ready_o = fetch_valid_i.
  - On consume: hword_q <= fetch_rdata_i[31:16], go to MISALIGNED. The low half is discarded; one bubble cycle.
- Branch handling:
  - branch_i has priority over everything in that cycle: instr_valid_o = 0 and fetch_ready_o = 0 (forced).
  - Next cycle: pc_q <= {branch_addr_i[31:1], 1'b0}; state <= branch_addr_i[1] ? BRANCH_MISALIGNED : ALIGNED.
  - The prefetch buffer flushes on the same branch_i; the next fetch word is the word containing the target.
- Boundary conditions:
  - Stall: instr_ready_i = 0 with valid high holds all state and outputs.
  - Empty fetch: fetch_valid_i = 0 in ALIGNED, or in MISALIGNED with a 32-bit start, gives instr_valid_o = 0. MISALIGNED with a compressed hword_q still issues.
  - PC arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFE + 2 gives 0.
  - Reset mid-operation discards hword_q and any partial instruction immediately (asynchronous).

Decomposition:
- riscv_nn_defines gets the typedef aligner_state_e {ALIGNED, MISALIGNED, BRANCH_MISALIGNED} (2-bit).
- No sub-module. riscv_nn_compressed_decoder is instantiated by the IF stage downstream of this block, not inside it.

Test Plan:
- Reset then branch to 0x100; words 0x00A00093, 0x00B00113, ready = 1 -> two outputs, PCs 0x100 and 0x104, data passed through, fetch_ready_o high in both cycles.
- Word 0x40854501 at 0x200 (c.li at 0x200, c.li at 0x202) -> outputs 0x00004501 @0x200 then 0x00004085 @0x202; second issues with fetch_ready_o = 0; back to ALIGNED.
- Word 0x00934501 then 0x12340513 -> 0x00004501 @0x300, straddling 32-bit 0x05130093 @0x302; hword_q = 0x1234 remains and issues next (compressed) @0x306.
- Branch to 0x402, word 0x0001ABCD -> bubble cycle (no output), then 0x00000001 @0x402.
- instr_ready_i = 0 for 5 cycles while in MISALIGNED with a straddling instruction -> instr_aligned_o and instr_addr_o constant, fetch_ready_o = 0, no PC change; resumes on ready.
- branch_i while a straddling instruction is pending -> that cycle valid = 0 and fetch_ready_o = 0; the pending half is dropped; next output is from the target. Assert rst_n low mid-stream -> valid = 0 immediately and PC = RESET_PC.
